rf_sel_penc_unit: RTL and testbench

//  Register-file selection primitive pair: WIDTH-bit 8:1 read-port mux plus 3-input write-port priority encoder.

---
 rtl/rf_pkg.sv | 18 +
 rtl/rf_sel_penc_unit_if.sv | 32 +++
 rtl/rf_sel_penc_unit_prio_enc3.sv | 22 ++
 rtl/rf_sel_penc_unit.sv | 67 ++++++
 tb/tb_rf_sel_penc_unit.sv | 137 +++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared register-file selection definitions.
//   REG_IDX_W / NUM_REGS : register index width and register count (8 registers).
//   pe_code_t            : write-port encoder codes. PE_NONE means "hold", and
//                          PE_P1..PE_P3 name write ports 1..3. The regfile's
//                          per-lane load decode reads these same codes.
package rf_pkg;

  localparam int REG_IDX_W = 3;
  localparam int NUM_REGS  = 8;

  typedef enum logic [1:0] {
    PE_NONE = 2'b00,
    PE_P1   = 2'b01,
    PE_P2   = 2'b10,
    PE_P3   = 2'b11
  } pe_code_t;

endpackage

// File: rtl/rf_sel_penc_unit_if.sv
// Bus bundle for rf_sel_penc_unit.
//   a0..a7    : mux data inputs (register values 0..7)
//   sel       : binary index of the register to read
//   mux_out   : combinational selected data; mux_out_q is its one-cycle copy
//   pe_a0..2  : load requests from write ports 1..3
//   pe_out    : combinational encoded winner; pe_out_q is its one-cycle copy
// There is no handshake on this bus. Inputs are sampled continuously, and the
// _q outputs always hold the value from the previous rising clock edge.
interface rf_sel_penc_unit_if #(
  parameter int WIDTH = 32
);
  import rf_pkg::*;

  logic [WIDTH-1:0]     a0, a1, a2, a3, a4, a5, a6, a7;
  logic [REG_IDX_W-1:0] sel;
  logic [WIDTH-1:0]     mux_out;
  logic [WIDTH-1:0]     mux_out_q;
  logic                 pe_a0, pe_a1, pe_a2;
  logic [1:0]           pe_out;
  logic [1:0]           pe_out_q;

  modport master (
    output a0, a1, a2, a3, a4, a5, a6, a7, sel, pe_a0, pe_a1, pe_a2,
    input  mux_out, mux_out_q, pe_out, pe_out_q
  );

  modport slave (
    input  a0, a1, a2, a3, a4, a5, a6, a7, sel, pe_a0, pe_a1, pe_a2,
    output mux_out, mux_out_q, pe_out, pe_out_q
  );

endinterface

// File: rtl/rf_sel_penc_unit_prio_enc3.sv
// rf_prio_enc3: combinational 3-input priority encoder. The highest-index
// request wins, so the youngest write port overrides the older ones.
//   req_p1..req_p3 : requests from write ports 1..3
//   code           : PE_P3 / PE_P2 / PE_P1, or PE_NONE when nothing is requested
// Lower-priority requests that lose are dropped without any indication.
module rf_prio_enc3
  import rf_pkg::*;
(
  input  logic     req_p1,
  input  logic     req_p2,
  input  logic     req_p3,
  output pe_code_t code
);

  always_comb begin
    code = PE_NONE;
    if (req_p3)      code = PE_P3;
    else if (req_p2) code = PE_P2;
    else if (req_p1) code = PE_P1;
  end

endmodule

// File: rtl/rf_sel_penc_unit.sv
// rf_sel_penc_unit: register-file selection pair.
//   - Read path: WIDTH-bit 8:1 mux on bus.sel, driving mux_out.
//   - Write path: 3-input priority encoder on bus.pe_a*, driving pe_out.
// Each path also has a copy registered one cycle later (mux_out_q and pe_out_q)
// for pipelined consumers.
// Ports:
//   clk   : single clock; all state updates on the rising edge
//   rst_n : synchronous active-low reset; clears only the _q registers
//   bus   : rf_sel_penc_unit_if slave modport (data, select, requests, outputs)
// Reset does not affect the combinational outputs, which keep tracking the
// inputs while rst_n is low.
module rf_sel_penc_unit
  import rf_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  rf_sel_penc_unit_if.slave   bus
);

  logic [WIDTH-1:0] mux_c;
  logic [WIDTH-1:0] mux_q;
  pe_code_t         pe_c;
  logic [1:0]       pe_q;

  // Read-port mux. Every select value is covered, so a known sel never yields X.
  always_comb begin
    mux_c = '0;
    case (bus.sel)
      3'd0:    mux_c = bus.a0;
      3'd1:    mux_c = bus.a1;
      3'd2:    mux_c = bus.a2;
      3'd3:    mux_c = bus.a3;
      3'd4:    mux_c = bus.a4;
      3'd5:    mux_c = bus.a5;
      3'd6:    mux_c = bus.a6;
      3'd7:    mux_c = bus.a7;
      default: mux_c = '0;
    endcase
  end

  // pe_a0..pe_a2 are the requests from write ports 1..3.
  rf_prio_enc3 u_prio_enc3 (
    .req_p1 (bus.pe_a0),
    .req_p2 (bus.pe_a1),
    .req_p3 (bus.pe_a2),
    .code   (pe_c)
  );

  // Output pipeline registers. There is no enable, so the latency is always exactly one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mux_q <= '0;
      pe_q  <= PE_NONE;
    end else begin
      mux_q <= mux_c;
      pe_q  <= pe_c;
    end
  end

  assign bus.mux_out   = mux_c;
  assign bus.pe_out    = pe_c;
  assign bus.mux_out_q = mux_q;
  assign bus.pe_out_q  = pe_q;

endmodule

// File: tb/tb_rf_sel_penc_unit.sv
// Bench for rf_sel_penc_unit. It uses a WIDTH=32 instance for the main tests
// and a WIDTH=8 instance for the narrow-build case.
module tb_rf_sel_penc_unit;

  logic clk;
  logic rst_n;

  rf_sel_penc_unit_if #(.WIDTH(32)) bus ();
  rf_sel_penc_unit_if #(.WIDTH(8))  bus8 ();

  rf_sel_penc_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  rf_sel_penc_unit #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial rst_n = 1'b0;

  // ---------------- scoreboard ----------------
  int unsigned      n_checks = 0;
  int unsigned      n_errors = 0;
  logic [31:0]      exp_q[$];
  logic [1:0]       pe_exp_q[$];
  logic [31:0]      a_val[8];
  logic [1:0]       pe_tab[8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_a();
    bus.a0 = a_val[0]; bus.a1 = a_val[1]; bus.a2 = a_val[2]; bus.a3 = a_val[3];
    bus.a4 = a_val[4]; bus.a5 = a_val[5]; bus.a6 = a_val[6]; bus.a7 = a_val[7];
  endtask

  // Each call drives one cycle. It checks the combinational outputs right away,
  // then checks the registered copy just after the next rising edge.
  task automatic step(input string tag, input logic r, input logic [2:0] s,
                      input logic [2:0] pe, input logic [31:0] exp_mux,
                      input logic [1:0] exp_pe);
    logic [31:0] em;
    logic [1:0]  ep;
    rst_n = r;
    bus.sel = s;
    {bus.pe_a2, bus.pe_a1, bus.pe_a0} = pe;
    #1;
    check({tag, "_mux"}, bus.mux_out, exp_mux);
    check({tag, "_pe"}, {30'b0, bus.pe_out}, {30'b0, exp_pe});
    exp_q.push_back(r ? exp_mux : 32'h0);
    pe_exp_q.push_back(r ? exp_pe : 2'b00);
    @(posedge clk);
    #1;
    em = exp_q.pop_front();
    ep = pe_exp_q.pop_front();
    check({tag, "_mux_q"}, bus.mux_out_q, em);
    check({tag, "_pe_q"}, {30'b0, bus.pe_out_q}, {30'b0, ep});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    pe_tab = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
    for (int i = 0; i < 8; i++) a_val[i] = 32'h1111_1111 * i;
    load_a();
    bus.sel = 3'd0;
    {bus.pe_a2, bus.pe_a1, bus.pe_a0} = 3'b000;
    bus8.a0 = 8'h3C; bus8.a1 = 8'h01; bus8.a2 = 8'h02; bus8.a3 = 8'h03;
    bus8.a4 = 8'h04; bus8.a5 = 8'h05; bus8.a6 = 8'h06; bus8.a7 = 8'hA5;
    bus8.sel = 3'd0;
    {bus8.pe_a2, bus8.pe_a1, bus8.pe_a0} = 3'b000;
    #2;

    // Reset state: the registers clear while the combinational outputs still follow the inputs.
    step("rst_init", 1'b0, 3'd3, 3'b010, 32'h3333_3333, 2'b10);

    // Sweep sel through 0..7.
    for (int i = 0; i < 8; i++)
      step($sformatf("sel%0d", i), 1'b1, 3'(i), 3'b000, 32'h1111_1111 * i, 2'b00);

    // All eight combinations of the encoder inputs.
    for (int p = 0; p < 8; p++)
      step($sformatf("pe%0d", p), 1'b1, 3'd1, 3'(p), 32'h1111_1111, pe_tab[p]);

    // Hold reset for two cycles with live inputs applied.
    a_val[5] = 32'hDEAD_BEEF;
    load_a();
    step("rst_hold0", 1'b0, 3'd5, 3'b111, 32'hDEAD_BEEF, 2'b11);
    step("rst_hold1", 1'b0, 3'd5, 3'b111, 32'hDEAD_BEEF, 2'b11);

    // First capture after reset is released.
    step("rst_rel", 1'b1, 3'd5, 3'b111, 32'hDEAD_BEEF, 2'b11);

    // One-cycle reset pulse in the middle of a stream of transactions.
    step("strm0", 1'b1, 3'd6, 3'b001, a_val[6], 2'b01);
    step("strm1", 1'b0, 3'd2, 3'b010, a_val[2], 2'b10);
    step("strm2", 1'b1, 3'd7, 3'b011, a_val[7], 2'b10);
    step("strm3", 1'b1, 3'd5, 3'b100, 32'hDEAD_BEEF, 2'b11);

    // Narrow build (WIDTH=8).
    bus8.sel = 3'd7;
    {bus8.pe_a2, bus8.pe_a1, bus8.pe_a0} = 3'b001;
    #1;
    check("w8_mux", {24'b0, bus8.mux_out}, 32'h0000_00A5);
    check("w8_pe", {30'b0, bus8.pe_out}, 32'h1);
    @(posedge clk);
    #1;
    check("w8_mux_q", {24'b0, bus8.mux_out_q}, 32'h0000_00A5);
    check("w8_pe_q", {30'b0, bus8.pe_out_q}, 32'h1);
    bus8.sel = 3'd0;
    #1;
    check("w8_mux_sel0", {24'b0, bus8.mux_out}, 32'h0000_003C);
    @(posedge clk);
    #1;
    check("w8_mux_q_sel0", {24'b0, bus8.mux_out_q}, 32'h0000_003C);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
